// File: rtl/multi_cycle_controller_pkg.sv
// Shared types and constants for the multi-cycle controller: FSM states,
// ALU control encodings, opcode/condition constants and the data-processing decode table.
package multi_cycle_controller_pkg;

   localparam int unsigned INSTR_W   = 32;
   localparam int unsigned FLAGS_W   = 4;
   localparam int unsigned ALU_CTL_W = 3;
   localparam int unsigned COND_W    = 4;
   localparam int unsigned OP_W      = 2;
   localparam int unsigned FUNCT_W   = 6;
   localparam int unsigned CMD_W     = 4;
   localparam int unsigned REG_ADR_W = 4;

   typedef enum logic [3:0] {
      FETCH     = 4'd0,
      DECODE    = 4'd1,
      MEM_ADR   = 4'd2,
      MEM_READ  = 4'd3,
      MEM_WB    = 4'd4,
      MEM_WRITE = 4'd5,
      EXEC_R    = 4'd6,
      EXEC_I    = 4'd7,
      ALU_WB    = 4'd8,
      BRANCH    = 4'd9
   } state_t;

   localparam logic [ALU_CTL_W-1:0] ALU_ADD = 3'b000;
   localparam logic [ALU_CTL_W-1:0] ALU_SUB = 3'b001;
   localparam logic [ALU_CTL_W-1:0] ALU_AND = 3'b010;
   localparam logic [ALU_CTL_W-1:0] ALU_ORR = 3'b011;
   localparam logic [ALU_CTL_W-1:0] ALU_EOR = 3'b100;
   localparam logic [ALU_CTL_W-1:0] ALU_ADC = 3'b101;
   localparam logic [ALU_CTL_W-1:0] ALU_SBC = 3'b110;

   localparam logic [OP_W-1:0] OP_DP  = 2'b00;
   localparam logic [OP_W-1:0] OP_MEM = 2'b01;
   localparam logic [OP_W-1:0] OP_BR  = 2'b10;
   localparam logic [OP_W-1:0] OP_NOP = 2'b11;

   localparam logic [COND_W-1:0] COND_EQ = 4'b0000;
   localparam logic [COND_W-1:0] COND_NE = 4'b0001;
   localparam logic [COND_W-1:0] COND_CS = 4'b0010;
   localparam logic [COND_W-1:0] COND_CC = 4'b0011;
   localparam logic [COND_W-1:0] COND_MI = 4'b0100;
   localparam logic [COND_W-1:0] COND_PL = 4'b0101;
   localparam logic [COND_W-1:0] COND_VS = 4'b0110;
   localparam logic [COND_W-1:0] COND_VC = 4'b0111;
   localparam logic [COND_W-1:0] COND_HI = 4'b1000;
   localparam logic [COND_W-1:0] COND_LS = 4'b1001;
   localparam logic [COND_W-1:0] COND_GE = 4'b1010;
   localparam logic [COND_W-1:0] COND_LT = 4'b1011;
   localparam logic [COND_W-1:0] COND_GT = 4'b1100;
   localparam logic [COND_W-1:0] COND_LE = 4'b1101;
   localparam logic [COND_W-1:0] COND_AL = 4'b1110;
   localparam logic [COND_W-1:0] COND_NV = 4'b1111;

   localparam logic [CMD_W-1:0] CMD_AND = 4'b0000;
   localparam logic [CMD_W-1:0] CMD_EOR = 4'b0001;
   localparam logic [CMD_W-1:0] CMD_SUB = 4'b0010;
   localparam logic [CMD_W-1:0] CMD_ADD = 4'b0100;
   localparam logic [CMD_W-1:0] CMD_ADC = 4'b0101;
   localparam logic [CMD_W-1:0] CMD_SBC = 4'b0110;
   localparam logic [CMD_W-1:0] CMD_TST = 4'b1000;
   localparam logic [CMD_W-1:0] CMD_TEQ = 4'b1001;
   localparam logic [CMD_W-1:0] CMD_CMP = 4'b1010;
   localparam logic [CMD_W-1:0] CMD_CMN = 4'b1011;
   localparam logic [CMD_W-1:0] CMD_ORR = 4'b1100;
   localparam logic [CMD_W-1:0] CMD_MOV = 4'b1101;

   typedef struct packed {
      logic [ALU_CTL_W-1:0] alu_ctl;
      logic                 shift;
      logic                 no_write;
      logic                 logical;
   } dp_ctl_t;

   // Data-processing command table; unlisted commands fall back to ADD.
   function automatic dp_ctl_t dp_decode(input logic [CMD_W-1:0] cmd);
      dp_ctl_t d;
      d = '{alu_ctl: ALU_ADD, shift: 1'b0, no_write: 1'b0, logical: 1'b0};
      case (cmd)
         CMD_AND: begin d.alu_ctl = ALU_AND; d.logical = 1'b1; end
         CMD_EOR: begin d.alu_ctl = ALU_EOR; d.logical = 1'b1; end
         CMD_SUB: d.alu_ctl = ALU_SUB;
         CMD_ADD: d.alu_ctl = ALU_ADD;
         CMD_ADC: d.alu_ctl = ALU_ADC;
         CMD_SBC: d.alu_ctl = ALU_SBC;
         CMD_TST: begin d.alu_ctl = ALU_AND; d.logical = 1'b1; d.no_write = 1'b1; end
         CMD_TEQ: begin d.alu_ctl = ALU_EOR; d.logical = 1'b1; d.no_write = 1'b1; end
         CMD_CMP: begin d.alu_ctl = ALU_SUB; d.no_write = 1'b1; end
         CMD_CMN: begin d.alu_ctl = ALU_ADD; d.no_write = 1'b1; end
         CMD_ORR: begin d.alu_ctl = ALU_ORR; d.logical = 1'b1; end
         CMD_MOV: begin d.shift = 1'b1; d.logical = 1'b1; end
         default: d.alu_ctl = ALU_ADD;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/multi_cycle_controller_cond_check.sv
// Evaluates an instruction condition field against the NZCV flags.
module multi_cycle_controller_cond_check
   import multi_cycle_controller_pkg::*;
(
   input  logic [COND_W-1:0]  cond,
   input  logic [FLAGS_W-1:0] flags,
   output logic               cond_ex
);

   logic n, z, c, v;

   assign {n, z, c, v} = flags;

   always_comb begin
      cond_ex = 1'b0;
      case (cond)
         COND_EQ: cond_ex = z;
         COND_NE: cond_ex = ~z;
         COND_CS: cond_ex = c;
         COND_CC: cond_ex = ~c;
         COND_MI: cond_ex = n;
         COND_PL: cond_ex = ~n;
         COND_VS: cond_ex = v;
         COND_VC: cond_ex = ~v;
         COND_HI: cond_ex = c & ~z;
         COND_LS: cond_ex = ~c | z;
         COND_GE: cond_ex = (n == v);
         COND_LT: cond_ex = (n != v);
         COND_GT: cond_ex = ~z & (n == v);
         COND_LE: cond_ex = z | (n != v);
         COND_AL: cond_ex = 1'b1;
         COND_NV: cond_ex = 1'b0;
         default: cond_ex = 1'b0;
      endcase
   end

endmodule

// File: rtl/multi_cycle_controller.sv
// Multi-cycle processor control unit: Moore FSM with instruction decode
// and the architectural NZCV flags register.
module multi_cycle_controller
   import multi_cycle_controller_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic [INSTR_W-1:0]   instr,
   input  logic [FLAGS_W-1:0]   alu_flags,
   output logic                 pc_write,
   output logic                 adr_src,
   output logic                 ir_write,
   output logic                 mem_write,
   output logic                 reg_write,
   output logic                 alu_src_a,
   output logic [1:0]           alu_src_b,
   output logic [1:0]           result_src,
   output logic [1:0]           imm_src,
   output logic [2:0]           reg_src,
   output logic [ALU_CTL_W-1:0] alu_ctl,
   output logic                 carry,
   output logic                 shift,
   output logic [FLAGS_W-1:0]   flags,
   output logic                 instr_done
);

   state_t               state, state_next;
   logic [COND_W-1:0]    cond;
   logic [OP_W-1:0]      op;
   logic [FUNCT_W-1:0]   funct;
   logic [REG_ADR_W-1:0] rd;
   logic                 cond_ex;
   dp_ctl_t              dp;
   logic                 flag_we;
   logic [FLAGS_W-1:0]   flags_next;
   logic                 unused_instr_bits;

   assign cond  = instr[31:28];
   assign op    = instr[27:26];
   assign funct = instr[25:20];
   assign rd    = instr[15:12];
   assign dp    = dp_decode(funct[4:1]);
   assign carry = flags[1];
   assign unused_instr_bits = ^{instr[19:16], instr[11:0]};

   multi_cycle_controller_cond_check u_cond_check (
      .cond    (cond),
      .flags   (flags),
      .cond_ex (cond_ex)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= FETCH;
      else       state <= state_next;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)        flags <= '0;
      else if (flag_we) flags <= flags_next;
   end

   // Next state, control outputs and flag update
   always_comb begin
      state_next = state;
      pc_write   = 1'b0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      result_src = 2'b00;
      imm_src    = 2'b00;
      reg_src    = 3'b000;
      alu_ctl    = ALU_ADD;
      shift      = 1'b0;
      instr_done = 1'b0;
      flag_we    = 1'b0;
      flags_next = flags;

      case (state)
         FETCH: begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            state_next = DECODE;
         end
         DECODE: begin
            if (!cond_ex || op == OP_NOP) begin
               instr_done = 1'b1;
               state_next = FETCH;
            end else begin
               case (op)
                  OP_DP:   state_next = funct[5] ? EXEC_I : EXEC_R;
                  OP_MEM:  state_next = MEM_ADR;
                  OP_BR:   state_next = BRANCH;
                  default: state_next = FETCH;
               endcase
            end
         end
         MEM_ADR: begin
            alu_src_b  = 2'b01;
            imm_src    = 2'b01;
            alu_ctl    = funct[3] ? ALU_ADD : ALU_SUB;
            state_next = funct[0] ? MEM_READ : MEM_WRITE;
         end
         MEM_READ: begin
            adr_src    = 1'b1;
            state_next = MEM_WB;
         end
         MEM_WB: begin
            adr_src    = 1'b1;
            reg_write  = 1'b1;
            result_src = 2'b01;
            pc_write   = (rd == REG_ADR_W'(15));
            instr_done = 1'b1;
            state_next = FETCH;
         end
         MEM_WRITE: begin
            adr_src    = 1'b1;
            mem_write  = 1'b1;
            reg_src    = 3'b010;
            instr_done = 1'b1;
            state_next = FETCH;
         end
         EXEC_R, EXEC_I: begin
            alu_src_b  = (state == EXEC_I) ? 2'b01 : 2'b00;
            alu_ctl    = dp.alu_ctl;
            shift      = dp.shift;
            flag_we    = funct[0];
            // Logical ops keep the stored C and V
            flags_next = dp.logical ? {alu_flags[3:2], flags[1:0]} : alu_flags;
            state_next = ALU_WB;
         end
         ALU_WB: begin
            reg_write  = ~dp.no_write;
            pc_write   = ~dp.no_write && (rd == REG_ADR_W'(15));
            instr_done = 1'b1;
            state_next = FETCH;
         end
         BRANCH: begin
            pc_write   = 1'b1;
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b01;
            imm_src    = 2'b10;
            result_src = 2'b10;
            reg_src    = 3'b001;
            instr_done = 1'b1;
            state_next = FETCH;
         end
         default: state_next = FETCH;
      endcase

      // Reset overrides the FETCH enables so nothing is written while held
      if (reset) begin
         pc_write   = 1'b0;
         ir_write   = 1'b0;
         mem_write  = 1'b0;
         reg_write  = 1'b0;
         instr_done = 1'b0;
      end
   end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Directed self-checking bench for multi_cycle_controller.
module tb_multi_cycle_controller;
   import multi_cycle_controller_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instr;
   logic [3:0]  alu_flags;
   logic        pc_write, adr_src, ir_write, mem_write, reg_write, alu_src_a;
   logic [1:0]  alu_src_b, result_src, imm_src;
   logic [2:0]  reg_src, alu_ctl;
   logic        carry, shift, instr_done;
   logic [3:0]  flags;

   int n_checks = 0;
   int n_errors = 0;

   logic [3:0] br_cond  [10] = '{4'h0, 4'h1, 4'h2, 4'h8, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
   logic       br_taken [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

   multi_cycle_controller dut (
      .clk        (clk),
      .reset      (reset),
      .instr      (instr),
      .alu_flags  (alu_flags),
      .pc_write   (pc_write),
      .adr_src    (adr_src),
      .ir_write   (ir_write),
      .mem_write  (mem_write),
      .reg_write  (reg_write),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .result_src (result_src),
      .imm_src    (imm_src),
      .reg_src    (reg_src),
      .alu_ctl    (alu_ctl),
      .carry      (carry),
      .shift      (shift),
      .flags      (flags),
      .instr_done (instr_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic check_fetch(input string tag);
      check({tag, " fetch state"}, 32'(dut.state), 32'(FETCH));
      check({tag, " fetch ir_write"}, 32'(ir_write), 32'd1);
      check({tag, " fetch pc_write"}, 32'(pc_write), 32'd1);
   endtask

   // Data-processing instruction, entered while in FETCH
   task automatic run_dp(input string tag, input logic [31:0] ins, input logic [3:0] af,
                         input state_t exec_st, input logic [2:0] ctl, input logic rw,
                         input logic pw, input logic [3:0] exp_flags);
      instr = ins;
      alu_flags = af;
      check_fetch(tag);
      check({tag, " fetch alu_src_b"}, 32'(alu_src_b), 32'd2);
      check({tag, " fetch result_src"}, 32'(result_src), 32'd2);
      step();
      check({tag, " decode state"}, 32'(dut.state), 32'(DECODE));
      check({tag, " decode done"}, 32'(instr_done), 32'd0);
      step();
      check({tag, " exec state"}, 32'(dut.state), 32'(exec_st));
      check({tag, " exec alu_ctl"}, 32'(alu_ctl), 32'(ctl));
      check({tag, " exec reg_write"}, 32'(reg_write), 32'd0);
      step();
      check({tag, " wb state"}, 32'(dut.state), 32'(ALU_WB));
      check({tag, " wb reg_write"}, 32'(reg_write), 32'(rw));
      check({tag, " wb pc_write"}, 32'(pc_write), 32'(pw));
      check({tag, " wb result_src"}, 32'(result_src), 32'd0);
      check({tag, " wb done"}, 32'(instr_done), 32'd1);
      check({tag, " flags"}, 32'(flags), 32'(exp_flags));
      step();
      check({tag, " next fetch"}, 32'(dut.state), 32'(FETCH));
   endtask

   task automatic run_b(input string tag, input logic [31:0] ins, input logic taken);
      instr = ins;
      check_fetch(tag);
      step();
      check({tag, " decode state"}, 32'(dut.state), 32'(DECODE));
      check({tag, " decode pc_write"}, 32'(pc_write), 32'd0);
      check({tag, " decode done"}, 32'(instr_done), 32'(!taken));
      step();
      if (taken) begin
         check({tag, " branch state"}, 32'(dut.state), 32'(BRANCH));
         check({tag, " branch pc_write"}, 32'(pc_write), 32'd1);
         check({tag, " branch imm_src"}, 32'(imm_src), 32'd2);
         check({tag, " branch reg_src"}, 32'(reg_src), 32'd1);
         check({tag, " branch alu_src_b"}, 32'(alu_src_b), 32'd1);
         check({tag, " branch done"}, 32'(instr_done), 32'd1);
         step();
      end
      check({tag, " end fetch"}, 32'(dut.state), 32'(FETCH));
   endtask

   initial begin
      reset = 1'b1;
      instr = 32'h0;
      alu_flags = 4'h0;
      #3;
      check("reset state", 32'(dut.state), 32'(FETCH));
      check("reset flags", 32'(flags), 32'd0);
      check("reset ir_write", 32'(ir_write), 32'd0);
      check("reset pc_write", 32'(pc_write), 32'd0);
      check("reset done", 32'(instr_done), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      check("reset held state", 32'(dut.state), 32'(FETCH));
      @(negedge clk);
      reset = 1'b0;
      #1;

      // ADD R1,R2,#5 without S: flags must ignore alu_flags
      run_dp("add_imm", 32'hE2821005, 4'hF, EXEC_I, ALU_ADD, 1'b1, 1'b0, 4'h0);

      // LDR R2,[R1,#4]
      instr = 32'hE5912004;
      check_fetch("ldr");
      step();
      check("ldr decode", 32'(dut.state), 32'(DECODE));
      step();
      check("ldr madr state", 32'(dut.state), 32'(MEM_ADR));
      check("ldr madr imm_src", 32'(imm_src), 32'd1);
      check("ldr madr alu_src_b", 32'(alu_src_b), 32'd1);
      check("ldr madr alu_ctl", 32'(alu_ctl), 32'(ALU_ADD));
      step();
      check("ldr mread state", 32'(dut.state), 32'(MEM_READ));
      check("ldr mread adr_src", 32'(adr_src), 32'd1);
      check("ldr mread reg_write", 32'(reg_write), 32'd0);
      step();
      check("ldr mwb state", 32'(dut.state), 32'(MEM_WB));
      check("ldr mwb adr_src", 32'(adr_src), 32'd1);
      check("ldr mwb reg_write", 32'(reg_write), 32'd1);
      check("ldr mwb result_src", 32'(result_src), 32'd1);
      check("ldr mwb done", 32'(instr_done), 32'd1);
      step();
      check("ldr end", 32'(dut.state), 32'(FETCH));

      // CMP R1,#0 loads full NZCV, no register write
      run_dp("cmp", 32'hE3510000, 4'b0110, EXEC_I, ALU_SUB, 1'b0, 1'b0, 4'b0110);
      check("cmp carry", 32'(carry), 32'd1);

      // BEQ with Z=1 is taken
      run_b("beq_z1", 32'h0A000002, 1'b1);

      // ANDS keeps C,V: 0110 -> {10,10}
      run_dp("ands", 32'hE2121005, 4'b1001, EXEC_I, ALU_AND, 1'b1, 1'b0, 4'b1010);
      check("ands carry", 32'(carry), 32'd1);

      // Condition table with NZCV=1010
      for (int i = 0; i < 10; i++)
         run_b($sformatf("cond%0h", br_cond[i]), {br_cond[i], 28'hA000002}, br_taken[i]);

      // STR to rd=15
      instr = 32'hE581F000;
      check_fetch("str");
      step();
      step();
      check("str madr state", 32'(dut.state), 32'(MEM_ADR));
      step();
      check("str mwrite state", 32'(dut.state), 32'(MEM_WRITE));
      check("str mem_write", 32'(mem_write), 32'd1);
      check("str adr_src", 32'(adr_src), 32'd1);
      check("str reg_src", 32'(reg_src), 32'd2);
      check("str pc_write", 32'(pc_write), 32'd0);
      check("str reg_write", 32'(reg_write), 32'd0);
      check("str done", 32'(instr_done), 32'd1);
      step();
      check("str end", 32'(dut.state), 32'(FETCH));

      // op=11 no-op
      instr = 32'hEC000000;
      check_fetch("nop");
      step();
      check("nop decode", 32'(dut.state), 32'(DECODE));
      check("nop done", 32'(instr_done), 32'd1);
      check("nop writes", 32'({pc_write, mem_write, reg_write, ir_write}), 32'd0);
      step();
      check("nop end", 32'(dut.state), 32'(FETCH));

      // ADD R15 writes the PC as well
      run_dp("add_pc", 32'hE282F005, 4'h0, EXEC_I, ALU_ADD, 1'b1, 1'b1, 4'b1010);

      // ORRS register form: 1010 -> {01,10}
      run_dp("orrs_reg", 32'hE1921003, 4'b0110, EXEC_R, ALU_ORR, 1'b1, 1'b0, 4'b0110);

      // Reset in the middle of an LDR
      instr = 32'hE5912004;
      step();
      step();
      step();
      check("rst pre state", 32'(dut.state), 32'(MEM_READ));
      reset = 1'b1;
      #1;
      check("rst async state", 32'(dut.state), 32'(FETCH));
      check("rst async flags", 32'(flags), 32'd0);
      check("rst async mem_write", 32'(mem_write), 32'd0);
      check("rst async reg_write", 32'(reg_write), 32'd0);
      check("rst async ir_write", 32'(ir_write), 32'd0);
      #1;
      reset = 1'b0;
      #1;
      check("rst release ir_write", 32'(ir_write), 32'd1);
      check("rst release state", 32'(dut.state), 32'(FETCH));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/multi_cycle_controller.md
MULTI_CYCLE_CONTROLLER -- requirements
Module: MultiCycleController

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset, named `clk` and `reset`.
REQ-002 SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- instr  in  32  instruction register contents: cond[31:28], op[27:26], funct[25:20], rd[15:12], bit[4]
- alu_flags  in  4  ALU NZCV for the current cycle
- pc_write  out  1  PC register load enable
- adr_src  out  1  memory address select: 0 = PC, 1 = ALU-out register
- ir_write  out  1  instruction register load enable
- mem_write  out  1  data memory write enable
- reg_write  out  1  register file write enable
- alu_src_a  out  1  ALU A select: 0 = register A, 1 = PC
- alu_src_b  out  2  ALU B select: 00 = shifted register, 01 = ext_imm, 10 = constant 4
- result_src  out  2  result select: 00 = ALU-out register, 01 = read data, 10 = ALU result
- imm_src  out  2  extend control, passed to Extend
- reg_src  out  3  register address selects, same encoding as the datapath
- alu_ctl  out  3  ALU operation
- carry  out  1  carry-in, equal to stored C
- shift  out  1  pass-through of B (MOV/shift operations)
- flags  out  4  architectural NZCV register
- instr_done  out  1  one-cycle pulse in the final state of each instruction

Function
REQ-003 SHALL be a Moore FSM with states FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I, ALU_WB, BRANCH.
REQ-004 FETCH SHALL assert ir_write=1, pc_write=1, adr_src=0, alu_src_a=1, alu_src_b=10, alu_ctl=ADD, result_src=10, and then go to DECODE.
REQ-005 DECODE SHALL evaluate cond against the flags register using all 15 ARM conditions; cond=1111 SHALL count as false.
REQ-006 If the condition is false in DECODE, the FSM SHALL return to FETCH with no write enables asserted and SHALL pulse instr_done.
REQ-007 If the condition is true, DECODE SHALL branch on op:
- op=00, funct[5]=0 -> EXEC_R
- op=00, funct[5]=1 -> EXEC_I
- op=01 -> MEM_ADR
- op=10 -> BRANCH
- op=11 -> FETCH as a no-op, with instr_done pulsed
REQ-008 MEM_ADR SHALL set alu_src_b=01, imm_src=01 and alu_ctl=ADD (SUB if funct[3]=0), then go to MEM_READ if funct[0]=1, else MEM_WRITE.
REQ-009 MEM_READ SHALL assert adr_src=1 and go to MEM_WB; MEM_WB SHALL assert reg_write=1 and result_src=01.
REQ-010 MEM_WRITE SHALL assert adr_src=1, mem_write=1 and reg_src[1]=1.
REQ-011 EXEC_R and EXEC_I SHALL decode funct[4:1] to alu_ctl/shift per the package table, then go to ALU_WB.
REQ-012 ALU_WB SHALL assert reg_write=1 and result_src=00, except for CMP/CMN/TST/TEQ, where reg_write=0.
REQ-013 In EXEC_R/EXEC_I, when funct[0]=1, the flags register SHALL load alu_flags on the clock edge.
- Logical operations SHALL update only N and Z.
REQ-014 BRANCH SHALL assert pc_write=1, alu_src_a=1, alu_src_b=01, imm_src=10, result_src=10 and reg_src[0]=1.
REQ-015 A register write with rd=15 SHALL also assert pc_write in the same cycle.
REQ-016 MEM_WB, MEM_WRITE, ALU_WB and BRANCH SHALL pulse instr_done and return to FETCH.
REQ-017 Latency in cycles, FETCH inclusive:
- data-processing: 4
- LDR: 5
- STR: 4
- B: 3
- condition-failed: 2
REQ-018 carry SHALL equal flags[1]; adc/sbc SHALL use it.

Reset
REQ-019 Asserting reset SHALL, asynchronously and in any state (including mid-instruction), force the state to FETCH and flags to 0000.
REQ-020 While reset is held, all write enables and instr_done SHALL be 0.
REQ-021 The first FETCH SHALL occur on the first rising clk edge after reset deasserts.

Structure
REQ-022 A shared package SHALL hold:
- the state enum
- alu_ctl encodings: ADD=000, SUB=001, AND=010, ORR=011, EOR=100, ADC=101, SBC=110
- op and condition-code constants
REQ-023 Condition evaluation SHALL be one sub-module, CondCheck (inputs cond and flags, output cond_ex); the rest SHALL be FSM plus decode in this module.

Verification
REQ-024 ADD R1,R2,#5 (E2821005) with flags 0 -> states FETCH, DECODE, EXEC_I, ALU_WB; reg_write=1 in cycle 4; alu_ctl=000; instr_done in cycle 4.
REQ-025 LDR R2,[R1,#4] (E5912004) -> states FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB; adr_src=1 in cycles 4–5; reg_write only in cycle 5.
REQ-026 CMP R1,#0 (E3510000) with ALU NZCV=0110 in EXEC_I -> flags=0110 after that edge; no reg_write in ALU_WB.
REQ-027 BEQ (0A000002) with Z=0 -> DECODE then FETCH, no pc_write in DECODE; with Z=1 -> BRANCH with pc_write=1.
REQ-028 Reset asserted mid-MEM_READ -> state is FETCH and flags are 0000 immediately, without a clock edge; mem_write and reg_write are 0.
REQ-029 STR to rd=15 and op=11 (EC000000) -> STR completes in 4 cycles with mem_write=1; op=11 returns to FETCH after DECODE with no writes.
